// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one multiplier core between two requesters
module mult_arbiter #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic        req1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        done0,
    output logic        done1,
    output logic [63:0] res,
    output logic        err,
    output logic        busy,
    output logic [31:0] m_A,
    output logic [31:0] m_B,
    output logic        m_init,
    input  logic        m_ready,
    input  logic [31:0] m_res_up,
    input  logic [31:0] m_res_dn
);
    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE, ABORT} state_t;
    state_t      state_q;
    logic        g_q, last_q, done0_q, done1_q, err_q, m_init_q;
    logic [15:0] cnt_q;
    logic [63:0] res_q;
    logic [31:0] m_a_q, m_b_q;
    logic        gnt_d, tmo_d;
    logic [15:0] cnt_d;
    // Arbitration choice, saturating watchdog increment and timeout detect
    always_comb begin
        gnt_d = (req0 && req1) ? ~last_q : req1;
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        tmo_d = (cnt_q == 16'(TIMEOUT - 1));
    end
    // Control FSM; done/res/err are set on entry to DONE/ABORT so they are visible in that state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            g_q      <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            m_a_q    <= '0;
            m_b_q    <= '0;
            m_init_q <= 1'b0;
            res_q    <= '0;
            err_q    <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                IDLE: if (req0 || req1) begin
                    g_q     <= gnt_d;
                    state_q <= LOAD;
                end
                LOAD: begin
                    m_a_q    <= g_q ? a1 : a0;
                    m_b_q    <= g_q ? b1 : b0;
                    m_init_q <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= START;
                end
                START: if (!m_ready) begin
                    m_init_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= RUN;
                end else if (tmo_d) begin
                    res_q    <= '0;
                    err_q    <= 1'b1;
                    m_init_q <= 1'b0;
                    done0_q  <= ~g_q;
                    done1_q  <= g_q;
                    state_q  <= ABORT;
                end else begin
                    cnt_q <= cnt_d;
                end
                RUN: if (m_ready) begin
                    res_q   <= {m_res_up, m_res_dn};
                    err_q   <= 1'b0;
                    done0_q <= ~g_q;
                    done1_q <= g_q;
                    state_q <= DONE;
                end else if (tmo_d) begin
                    res_q    <= '0;
                    err_q    <= 1'b1;
                    m_init_q <= 1'b0;
                    done0_q  <= ~g_q;
                    done1_q  <= g_q;
                    state_q  <= ABORT;
                end else begin
                    cnt_q <= cnt_d;
                end
                DONE, ABORT: begin
                    last_q  <= g_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign res    = res_q;
    assign err    = err_q;
    assign busy   = (state_q != IDLE);
    assign m_A    = m_a_q;
    assign m_B    = m_b_q;
    assign m_init = m_init_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: scoreboard bench for mult_arbiter with a behavioural multiplier core
module tb_mult_arbiter;
    logic        clk = 1'b0;
    logic        rst, req0, req1, m_ready, m_init, done0, done1, err, busy;
    logic [31:0] a0, b0, a1, b1, m_A, m_B, m_res_up, m_res_dn;
    logic [63:0] res;
    logic        core_stuck;
    logic [63:0] op_a, op_b;
    int          cd;
    int          errors = 0;
    int          checks = 0;
    typedef struct {int id; logic [63:0] res; logic err;} exp_t;
    exp_t        sb[$];

    mult_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .res(res), .err(err), .busy(busy),
        .m_A(m_A), .m_B(m_B), .m_init(m_init), .m_ready(m_ready),
        .m_res_up(m_res_up), .m_res_dn(m_res_dn)
    );

    always #5 clk = ~clk;

    // Core model: drops ready when it sees init, returns the product 3 cycles later
    always @(posedge clk) begin
        if (!rst) begin
            m_ready <= 1'b1;
            cd <= 0;
            op_a <= '0;
            op_b <= '0;
            {m_res_up, m_res_dn} <= '0;
        end else if (core_stuck) begin
            m_ready <= 1'b1;
        end else if (m_init && m_ready) begin
            m_ready <= 1'b0;
            cd <= 3;
            op_a <= {32'd0, m_A};
            op_b <= {32'd0, m_B};
        end else if (!m_ready) begin
            if (cd <= 1) begin
                m_ready <= 1'b1;
                {m_res_up, m_res_dn} <= op_a * op_b;
            end else begin
                cd <= cd - 1;
            end
        end
    end

    task automatic wait_done(output int id, output logic [63:0] r, output logic e,
                             output bit ok, output int mi, output bit both);
        ok = 0; mi = 0; both = 0; id = -1; r = '0; e = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (m_init) mi++;
            if (done0 || done1) begin
                ok = 1;
                id = done1 ? 1 : 0;
                both = done0 && done1;
                r = res;
                e = err;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; core_stuck = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({done0, done1, err, busy, m_init, res, m_A, m_B} !== '0) begin
            errors++;
            $display("FAIL reset_state: got d0=%b d1=%b err=%b busy=%b init=%b res=%h A=%h B=%h, want all 0",
                     done0, done1, err, busy, m_init, res, m_A, m_B);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int id; logic [63:0] r; logic e; bit ok, both; int mi; exp_t x;
        a0 = 32'd7; b0 = 32'd6; req0 = 1'b1;
        sb.push_back('{0, 64'd42, 1'b0});
        wait_done(id, r, e, ok, mi, both);
        req0 = 1'b0;
        x = sb.pop_front();
        checks++;
        if (!ok || id !== x.id || r !== x.res || e !== x.err || both) begin
            errors++;
            $display("FAIL single: got ok=%0d id=%0d res=%h err=%b both=%b, want id=%0d res=%h err=%b",
                     ok, id, r, e, both, x.id, x.res, x.err);
        end
        checks++;
        if (mi < 1 || m_init !== 1'b0) begin
            errors++;
            $display("FAIL single_init: got init_cycles=%0d init_at_done=%b, want >=1 and 0", mi, m_init);
        end
    endtask

    task automatic test_full_width();
        int id; logic [63:0] r; logic e; bit ok, both; int mi; exp_t x;
        a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF; req1 = 1'b1;
        sb.push_back('{1, 64'hFFFF_FFFE_0000_0001, 1'b0});
        wait_done(id, r, e, ok, mi, both);
        req1 = 1'b0;
        x = sb.pop_front();
        checks++;
        if (!ok || id !== x.id || r !== x.res || e !== x.err || both) begin
            errors++;
            $display("FAIL full_width: got ok=%0d id=%0d res=%h err=%b, want id=%0d res=%h err=%b",
                     ok, id, r, e, x.id, x.res, x.err);
        end
        @(negedge clk);
        checks++;
        if (res !== 64'hFFFF_FFFE_0000_0001 || busy !== 1'b0) begin
            errors++;
            $display("FAIL res_hold: got res=%h busy=%b, want res=fffffffe00000001 busy=0", res, busy);
        end
    endtask

    task automatic test_contention();
        int id; logic [63:0] r; logic e; bit ok, both; int mi; exp_t x;
        a0 = 32'd1000; b0 = 32'd3; a1 = 32'd12345; b1 = 32'd678;
        req0 = 1'b1; req1 = 1'b1;
        sb.push_back('{0, 64'd3000, 1'b0});
        sb.push_back('{1, 64'd8369910, 1'b0});
        for (int k = 0; k < 2; k++) begin
            wait_done(id, r, e, ok, mi, both);
            if (id == 0) req0 = 1'b0;
            if (id == 1) req1 = 1'b0;
            x = sb.pop_front();
            checks++;
            if (!ok || id !== x.id || r !== x.res || e !== x.err || both) begin
                errors++;
                $display("FAIL contention[%0d]: got ok=%0d id=%0d res=%h err=%b both=%b, want id=%0d res=%h err=%b",
                         k, ok, id, r, e, both, x.id, x.res, x.err);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_sustained();
        int id; logic [63:0] r; logic e; bit ok, both; int mi; exp_t x;
        a0 = 32'd11; b0 = 32'd13; a1 = 32'h1_0000; b1 = 32'h1_0000;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 6; k++)
            sb.push_back((k % 2 == 0) ? '{0, 64'd143, 1'b0} : '{1, 64'h1_0000_0000, 1'b0});
        for (int k = 0; k < 6; k++) begin
            wait_done(id, r, e, ok, mi, both);
            if (k == 5) begin req0 = 1'b0; req1 = 1'b0; end
            x = sb.pop_front();
            checks++;
            if (!ok || id !== x.id || r !== x.res || e !== x.err || both) begin
                errors++;
                $display("FAIL sustained[%0d]: got ok=%0d id=%0d res=%h err=%b both=%b, want id=%0d res=%h err=%b",
                         k, ok, id, r, e, both, x.id, x.res, x.err);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_timeout();
        int id; logic [63:0] r; logic e; bit ok, both; int mi; exp_t x;
        core_stuck = 1'b1;
        a0 = 32'd5; b0 = 32'd5; req0 = 1'b1;
        sb.push_back('{0, 64'd0, 1'b1});
        wait_done(id, r, e, ok, mi, both);
        req0 = 1'b0;
        x = sb.pop_front();
        checks++;
        if (!ok || id !== x.id || r !== x.res || e !== x.err) begin
            errors++;
            $display("FAIL timeout: got ok=%0d id=%0d res=%h err=%b, want id=%0d res=%h err=%b",
                     ok, id, r, e, x.id, x.res, x.err);
        end
        checks++;
        if (mi !== 8) begin
            errors++;
            $display("FAIL timeout_start_cycles: got %0d, want 8", mi);
        end
        @(negedge clk);
        core_stuck = 1'b0;
        a0 = 32'd9; b0 = 32'd11; req0 = 1'b1;
        sb.push_back('{0, 64'd99, 1'b0});
        wait_done(id, r, e, ok, mi, both);
        req0 = 1'b0;
        x = sb.pop_front();
        checks++;
        if (!ok || id !== x.id || r !== x.res || e !== x.err) begin
            errors++;
            $display("FAIL after_timeout: got ok=%0d id=%0d res=%h err=%b, want id=%0d res=%h err=%b",
                     ok, id, r, e, x.id, x.res, x.err);
        end
    endtask

    task automatic test_reset_midop();
        int id; logic [63:0] r; logic e; bit ok, both; int mi; exp_t x;
        bit seen_hi, in_run;
        seen_hi = 0; in_run = 0;
        a0 = 32'd3; b0 = 32'd4; req0 = 1'b1;
        for (int i = 0; i < 50 && !in_run; i++) begin
            @(negedge clk);
            if (m_init) seen_hi = 1;
            else if (seen_hi) in_run = 1;
        end
        checks++;
        if (!in_run) begin
            errors++;
            $display("FAIL midop_reach_run: got in_run=0, want 1 within 50 cycles");
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({done0, done1, m_init, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL midop_reset: got d0=%b d1=%b init=%b busy=%b, want 0000",
                     done0, done1, m_init, busy);
        end
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        a0 = 32'd2; b0 = 32'd2; a1 = 32'd3; b1 = 32'd3;
        req0 = 1'b1; req1 = 1'b1;
        sb.push_back('{0, 64'd4, 1'b0});
        sb.push_back('{1, 64'd9, 1'b0});
        for (int k = 0; k < 2; k++) begin
            wait_done(id, r, e, ok, mi, both);
            if (id == 0) req0 = 1'b0;
            if (id == 1) req1 = 1'b0;
            x = sb.pop_front();
            checks++;
            if (!ok || id !== x.id || r !== x.res || e !== x.err || both) begin
                errors++;
                $display("FAIL post_reset_grant[%0d]: got ok=%0d id=%0d res=%h err=%b, want id=%0d res=%h err=%b",
                         k, ok, id, r, e, x.id, x.res, x.err);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_width();
        test_contention();
        test_sustained();
        test_timeout();
        test_reset_midop();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end
endmodule
